rv32i_mem_arbiter: RTL and testbench
====================================

# rv32i_mem_arbiter

Two-master arbiter for the single 16-bit system memory port. It shares the port between the rv32i control unit (master 0) and a secondary master such as DMA or debug (master 1). Multi-beat accesses (32-bit loads/stores split into two halfword beats) are kept atomic through a lock input. A hold limit bounds how long one master can starve the other.

## Interface
- XLEN, 32, address width
- DATA_BITS, 16, memory data/mask width
- HOLD_MAX, 8, max beats per ownership while the other master waits (≥2)

- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- mN_req_i  in  1  master N requests a beat (N = 0, 1)
- mN_lock_i  in  1  keep ownership after this beat
- mN_we_i  in  1  beat is a write
- mN_addr_i  in  XLEN  beat address
- mN_data_i  in  DATA_BITS  write data
- mN_mask_i  in  DATA_BITS  write mask, passed through unchanged
- mN_gnt_o  out  1  master N owns the port this cycle
- mN_data_o  out  DATA_BITS  read data, valid with mN_rvalid_o
- mN_rvalid_o  out  1  read data for master N's previous read beat
- mem_addr_o  out  XLEN  to memory
- mem_read_o  out  1  read strobe
- mem_write_o  out  1  write strobe
- mem_data_o  out  DATA_BITS  write data
- mem_mask_o  out  DATA_BITS  write mask
- mem_data_i  in  DATA_BITS  memory read data, 1-cycle synchronous latency

## Operation
- FSM states: IDLE, OWN0, OWN1. State, last_owner, hold_cnt and rd_tag are registers.
- IDLE: no gnt. If any req is high, the winner is chosen per Configuration and the FSM enters OWNx next cycle.
- OWNx:
  - mx_gnt_o=1.
  - mem_* outputs are combinationally muxed from master x.
  - Each cycle with mx_req_i=1 issues one beat: mem_read_o=~we or mem_write_o=we.
  - The non-owner's req is ignored; it holds its request until granted.
- Exit from OWNx (evaluated every cycle):
  - req_x=1 & lock_x=0: this is the last beat. Next state is OWNy if req_y=1, else IDLE. There is no idle bubble on handover.
  - req_x=0: no beat is issued. Next state is OWNy if req_y=1, else IDLE.
  - req_x=1 & lock_x=1: stay in OWNx, unless hold_cnt==HOLD_MAX-1 and req_y=1. In that case this is a forced release: the beat completes, then the FSM goes to OWNy.
- hold_cnt: cleared on every state change and incremented per issued beat. It saturates at HOLD_MAX-1 when req_y=0, so the lock is held indefinitely while uncontended.
- last_owner is updated on every transition into OWNx.
- Read return:
  - rd_tag registers {read issued, owner}.
  - The next cycle asserts the tagged mN_rvalid_o for 1 cycle.
  - mem_data_i is broadcast to both mN_data_o.
  - Read data still returns correctly when the handover happened in between.
- Outside OWNx, mem_addr_o/data/mask are driven 0 and the strobes are 0.

## Timing
- Reset values: state=IDLE, all gnt/rvalid/strobes=0, mem_addr_o/data/mask=0, hold_cnt=0, last_owner=1 (so master 0 wins the first tie).
- Grant latency: req rises in cycle t; gnt is asserted in t+1; the first beat is issued in t+1.
- Back-to-back handover: the last beat of x in cycle t, then gnt_y in t+1 with y's beat in t+1.
- Read latency: beat in t, rvalid in t+1.
- Write completes in the beat cycle.
- Reset asserted mid-operation: state returns to IDLE asynchronously and all outputs go to reset values immediately. A pending rvalid is dropped.

## Configuration
- RV32I_ARB_ROUND_ROBIN_EN defined: on simultaneous requests from IDLE, the master other than last_owner wins.
- RV32I_ARB_ROUND_ROBIN_EN undefined: fixed priority, master 0 always wins ties from IDLE. Handover and hold-limit rules are unchanged, so master 1 is still never starved past HOLD_MAX beats.

## Test plan
- Reset, then m0 read at 0x100 with memory returning 0xBEEF: m0_gnt_o in cycle 1, mem_read_o in cycle 1, m0_rvalid_o=1 and m0_data_o=0xBEEF in cycle 2; m1 outputs stay 0.
- m0 locked two-beat write (0x200, 0x202) while m1 requests from beat 1: m1 is not granted until the cycle after beat 2; the two m0 writes are contiguous.
- m0 holds lock continuously, m1 requesting, HOLD_MAX=8: exactly 8 m0 beats, then m1_gnt_o in the next cycle.
- m0 and m1 request simultaneously from IDLE twice: with the macro defined, grants go m0 then m1; without it, m0 both times.
- m1 read is the final beat before handover to m0: m1_rvalid_o (not m0) asserts in the first m0 ownership cycle.
- reset_i pulsed mid-beat during OWN1: gnt, strobes and rvalid drop within the same cycle; after release, the first request sees a grant latency of 1 cycle.

Source files
------------

// File: rtl/rv32i_mem_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the 16-bit memory port.
// Modports: slave = arbiter side, master = requester/memory side.
interface rv32i_mem_arbiter_if #(
  parameter int XLEN      = 32,
  parameter int DATA_BITS = 16
);
  logic                 m0_req_i;
  logic                 m0_lock_i;
  logic                 m0_we_i;
  logic [XLEN-1:0]      m0_addr_i;
  logic [DATA_BITS-1:0] m0_data_i;
  logic [DATA_BITS-1:0] m0_mask_i;
  logic                 m0_gnt_o;
  logic [DATA_BITS-1:0] m0_data_o;
  logic                 m0_rvalid_o;

  logic                 m1_req_i;
  logic                 m1_lock_i;
  logic                 m1_we_i;
  logic [XLEN-1:0]      m1_addr_i;
  logic [DATA_BITS-1:0] m1_data_i;
  logic [DATA_BITS-1:0] m1_mask_i;
  logic                 m1_gnt_o;
  logic [DATA_BITS-1:0] m1_data_o;
  logic                 m1_rvalid_o;

  logic [XLEN-1:0]      mem_addr_o;
  logic                 mem_read_o;
  logic                 mem_write_o;
  logic [DATA_BITS-1:0] mem_data_o;
  logic [DATA_BITS-1:0] mem_mask_o;
  logic [DATA_BITS-1:0] mem_data_i;

  modport slave (
    input  m0_req_i, m0_lock_i, m0_we_i,
    input  m0_addr_i, m0_data_i, m0_mask_i,
    output m0_gnt_o, m0_data_o, m0_rvalid_o,
    input  m1_req_i, m1_lock_i, m1_we_i,
    input  m1_addr_i, m1_data_i, m1_mask_i,
    output m1_gnt_o, m1_data_o, m1_rvalid_o,
    output mem_addr_o, mem_read_o, mem_write_o,
    output mem_data_o, mem_mask_o,
    input  mem_data_i
  );

  modport master (
    output m0_req_i, m0_lock_i, m0_we_i,
    output m0_addr_i, m0_data_i, m0_mask_i,
    input  m0_gnt_o, m0_data_o, m0_rvalid_o,
    output m1_req_i, m1_lock_i, m1_we_i,
    output m1_addr_i, m1_data_i, m1_mask_i,
    input  m1_gnt_o, m1_data_o, m1_rvalid_o,
    input  mem_addr_o, mem_read_o, mem_write_o,
    input  mem_data_o, mem_mask_o,
    output mem_data_i
  );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Two-master arbiter for the 16-bit memory port with lock and hold limit.
// Ports: clk_i, reset_i (async, high), bus (rv32i_mem_arbiter_if.slave).
// Macro RV32I_ARB_ROUND_ROBIN_EN: round-robin tie break from IDLE.
module rv32i_mem_arbiter #(
  parameter int XLEN      = 32,
  parameter int DATA_BITS = 16,
  parameter int HOLD_MAX  = 8
) (
  input logic                clk_i,
  input logic                reset_i,
  rv32i_mem_arbiter_if.slave bus
);

  localparam int HW = $clog2(HOLD_MAX);
  localparam logic [HW-1:0] HOLD_TOP = HW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e          state_q, state_d;
  logic            last_owner_q, last_owner_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            rd_vld_q, rd_vld_d;
  logic            rd_own_q, rd_own_d;

  logic                 own1, own_any;
  logic                 req_x, lock_x, we_x, req_y;
  logic [XLEN-1:0]      addr_x;
  logic [DATA_BITS-1:0] data_x, mask_x;
  logic                 beat, hold_top, win1;

`ifdef RV32I_ARB_ROUND_ROBIN_EN
  // On a tie the master that did not own last gets the port.
  assign win1 = bus.m1_req_i & (~bus.m0_req_i | ~last_owner_q);
`else
  assign win1 = ~bus.m0_req_i;
  logic unused_last_owner;
  assign unused_last_owner = last_owner_q;
`endif

  always_comb begin
    own1    = (state_q == OWN1);
    own_any = (state_q != IDLE);
    req_x   = own1 ? bus.m1_req_i  : bus.m0_req_i;
    lock_x  = own1 ? bus.m1_lock_i : bus.m0_lock_i;
    we_x    = own1 ? bus.m1_we_i   : bus.m0_we_i;
    addr_x  = own1 ? bus.m1_addr_i : bus.m0_addr_i;
    data_x  = own1 ? bus.m1_data_i : bus.m0_data_i;
    mask_x  = own1 ? bus.m1_mask_i : bus.m0_mask_i;
    req_y   = own1 ? bus.m0_req_i  : bus.m1_req_i;
    beat     = own_any & req_x;
    hold_top = (hold_cnt_q == HOLD_TOP);
  end

  always_comb begin
    bus.mem_addr_o  = own_any ? addr_x : '0;
    bus.mem_data_o  = own_any ? data_x : '0;
    bus.mem_mask_o  = own_any ? mask_x : '0;
    bus.mem_read_o  = beat & ~we_x;
    bus.mem_write_o = beat & we_x;
    bus.m0_gnt_o    = (state_q == OWN0);
    bus.m1_gnt_o    = own1;
    bus.m0_rvalid_o = rd_vld_q & ~rd_own_q;
    bus.m1_rvalid_o = rd_vld_q & rd_own_q;
    // Read data is broadcast; rvalid tells who it belongs to.
    bus.m0_data_o   = bus.mem_data_i;
    bus.m1_data_o   = bus.mem_data_i;
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (bus.m0_req_i | bus.m1_req_i)
          state_d = win1 ? OWN1 : OWN0;
      end
      OWN0, OWN1: begin
        // Stay only while locked and not forced out by the hold limit.
        if (!(req_x & lock_x & ~(hold_top & req_y)))
          state_d = req_y ? (own1 ? OWN0 : OWN1) : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q && state_d != IDLE)
      last_owner_d = (state_d == OWN1);

    // Saturates while uncontended so the lock can be held forever.
    if (state_d != state_q)
      hold_cnt_d = '0;
    else if (beat && !hold_top)
      hold_cnt_d = hold_cnt_q + HW'(1);
    else
      hold_cnt_d = hold_cnt_q;

    rd_vld_d = beat & ~we_x;
    rd_own_d = own1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      hold_cnt_q   <= '0;
      rd_vld_q     <= 1'b0;
      rd_own_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      rd_vld_q     <= rd_vld_d;
      rd_own_q     <= rd_own_d;
    end
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter with a read-return scoreboard.
// Honours RV32I_ARB_ROUND_ROBIN_EN for the tie-break expectation.
module tb_rv32i_mem_arbiter;

`ifdef RV32I_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rv32i_mem_arbiter_if bus ();

  rv32i_mem_arbiter #(.HOLD_MAX(8)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  function automatic logic [15:0] memf(input logic [31:0] a);
    logic [15:0] lo;
    lo = a[15:0];
    return (a == 32'h100) ? 16'hBEEF : (lo ^ 16'h5A5A);
  endfunction

  logic [15:0] mem_q = '0;
  always @(posedge clk)
    if (bus.mem_read_o) mem_q <= memf(bus.mem_addr_o);
  assign bus.mem_data_i = mem_q;

  typedef struct {
    bit          own;
    logic [15:0] data;
    int          due;
  } rd_t;
  rd_t sb[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit m, input bit req, input bit lock,
                     input bit we, input logic [31:0] a,
                     input logic [15:0] d);
    if (m) begin
      bus.m1_req_i = req;  bus.m1_lock_i = lock; bus.m1_we_i = we;
      bus.m1_addr_i = a;   bus.m1_data_i = d;    bus.m1_mask_i = ~d;
    end else begin
      bus.m0_req_i = req;  bus.m0_lock_i = lock; bus.m0_we_i = we;
      bus.m0_addr_i = a;   bus.m0_data_i = d;    bus.m0_mask_i = ~d;
    end
  endtask

  task automatic push(input bit m, input logic [31:0] a);
    rd_t e;
    e.own = m; e.data = memf(a); e.due = cyc + 1;
    sb.push_back(e);
  endtask

  // Mid-cycle sample point; also retires any read due this cycle.
  task automatic at_neg();
    rd_t e;
    @(negedge clk);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rvalid0", bus.m0_rvalid_o, !e.own);
      chk("rvalid1", bus.m1_rvalid_o, e.own);
      chk("rdata", e.own ? bus.m1_data_o : bus.m0_data_o, e.data);
    end else begin
      chk("rvalid0_quiet", bus.m0_rvalid_o, 0);
      chk("rvalid1_quiet", bus.m1_rvalid_o, 0);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_gnt(input string tag, input bit g0, input bit g1);
    chk({tag, "_gnt0"}, bus.m0_gnt_o, g0);
    chk({tag, "_gnt1"}, bus.m1_gnt_o, g1);
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;

    // Reset state
    @(negedge clk);
    chk_gnt("rst", 0, 0);
    chk("rst_rvalid", {bus.m0_rvalid_o, bus.m1_rvalid_o}, 0);
    chk("rst_strobe", {bus.mem_read_o, bus.mem_write_o}, 0);
    chk("rst_addr", bus.mem_addr_o, 0);
    chk("rst_dm", {bus.mem_data_o, bus.mem_mask_o}, 0);
    next();
    rst = 1'b0;
    cyc = 0;

    // m0 single read at 0x100
    drv(0, 1, 0, 0, 32'h100, 0);
    at_neg(); chk_gnt("t1c0", 0, 0);
    chk("t1c0_rd", bus.mem_read_o, 0);
    next();
    at_neg(); chk_gnt("t1c1", 1, 0);
    chk("t1c1_rd", bus.mem_read_o, 1);
    chk("t1c1_addr", bus.mem_addr_o, 32'h100);
    push(0, 32'h100);
    next();
    drv(0, 0, 0, 0, 0, 0);
    at_neg(); chk_gnt("t1c2", 0, 0);
    next();

    // m0 locked two-beat write, m1 waits
    drv(0, 1, 1, 1, 32'h200, 16'h1111);
    at_neg(); chk_gnt("t2c0", 0, 0);
    next();
    drv(1, 1, 0, 0, 32'h300, 0);
    at_neg(); chk_gnt("t2b1", 1, 0);
    chk("t2b1_wr", bus.mem_write_o, 1);
    chk("t2b1_addr", bus.mem_addr_o, 32'h200);
    chk("t2b1_data", bus.mem_data_o, 16'h1111);
    chk("t2b1_mask", bus.mem_mask_o, 16'hEEEE);
    next();
    drv(0, 1, 0, 1, 32'h202, 16'h2222);
    at_neg(); chk_gnt("t2b2", 1, 0);
    chk("t2b2_wr", bus.mem_write_o, 1);
    chk("t2b2_addr", bus.mem_addr_o, 32'h202);
    next();
    drv(0, 0, 0, 0, 0, 0);
    at_neg(); chk_gnt("t2h", 0, 1);
    chk("t2h_rd", bus.mem_read_o, 1);
    chk("t2h_addr", bus.mem_addr_o, 32'h300);
    push(1, 32'h300);
    next();
    drv(1, 0, 0, 0, 0, 0);
    at_neg(); chk_gnt("t2e", 0, 0);
    next();

    // Hold limit: 8 locked m0 beats then m1
    drv(0, 1, 1, 1, 32'h400, 16'h0400);
    drv(1, 1, 0, 1, 32'h4F0, 16'h4F0F);
    at_neg(); chk_gnt("t3c0", 0, 0);
    next();
    for (int i = 0; i < 8; i++) begin
      drv(0, 1, 1, 1, 32'h400 + 2 * i, 16'(i));
      at_neg(); chk_gnt("t3b", 1, 0);
      chk("t3b_wr", bus.mem_write_o, 1);
      chk("t3b_addr", bus.mem_addr_o, 32'h400 + 2 * i);
      next();
    end
    drv(0, 0, 0, 0, 0, 0);
    at_neg(); chk_gnt("t3h", 0, 1);
    chk("t3h_wr", bus.mem_write_o, 1);
    chk("t3h_addr", bus.mem_addr_o, 32'h4F0);
    next();
    drv(1, 0, 0, 0, 0, 0);
    at_neg(); chk_gnt("t3e", 0, 0);
    next();

    // Two ties from IDLE
    drv(0, 1, 0, 0, 32'h500, 0);
    drv(1, 1, 0, 0, 32'h600, 0);
    at_neg(); chk_gnt("t4a0", 0, 0);
    next();
    drv(1, 0, 0, 0, 0, 0);
    at_neg(); chk_gnt("t4a1", 1, 0);
    chk("t4a1_addr", bus.mem_addr_o, 32'h500);
    push(0, 32'h500);
    next();
    drv(0, 1, 0, 0, 32'h510, 0);
    drv(1, 1, 0, 0, 32'h610, 0);
    at_neg(); chk_gnt("t4b0", 0, 0);
    next();
    if (RR) drv(0, 0, 0, 0, 0, 0);
    else    drv(1, 0, 0, 0, 0, 0);
    at_neg(); chk_gnt("t4b1", !RR, RR);
    chk("t4b1_addr", bus.mem_addr_o, RR ? 32'h610 : 32'h510);
    push(RR, RR ? 32'h610 : 32'h510);
    next();
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    at_neg(); chk_gnt("t4e", 0, 0);
    next();

    // m1 read is last beat before handover to m0
    drv(1, 1, 0, 0, 32'h700, 0);
    at_neg(); chk_gnt("t5c0", 0, 0);
    next();
    drv(0, 1, 0, 0, 32'h800, 0);
    at_neg(); chk_gnt("t5c1", 0, 1);
    chk("t5c1_addr", bus.mem_addr_o, 32'h700);
    push(1, 32'h700);
    next();
    drv(1, 0, 0, 0, 0, 0);
    at_neg(); chk_gnt("t5c2", 1, 0);
    chk("t5c2_addr", bus.mem_addr_o, 32'h800);
    push(0, 32'h800);
    next();
    drv(0, 0, 0, 0, 0, 0);
    at_neg(); chk_gnt("t5e", 0, 0);
    next();

    // Reset pulsed mid-beat in OWN1
    drv(1, 1, 1, 0, 32'h900, 0);
    at_neg(); chk_gnt("t6c0", 0, 0);
    next();
    at_neg(); chk_gnt("t6c1", 0, 1);
    chk("t6c1_rd", bus.mem_read_o, 1);
    next();
    chk("t6pre_rvalid1", bus.m1_rvalid_o, 1);
    chk("t6pre_data", bus.m1_data_o, memf(32'h900));
    chk("t6pre_gnt1", bus.m1_gnt_o, 1);
    #2 rst = 1'b1;
    #1;
    chk_gnt("t6rst", 0, 0);
    chk("t6rst_strobe", {bus.mem_read_o, bus.mem_write_o}, 0);
    chk("t6rst_rvalid", {bus.m0_rvalid_o, bus.m1_rvalid_o}, 0);
    chk("t6rst_addr", bus.mem_addr_o, 0);
    next();
    rst = 1'b0;
    drv(1, 0, 0, 0, 0, 0);
    drv(0, 1, 0, 0, 32'hA00, 0);
    at_neg(); chk_gnt("t6s0", 0, 0);
    next();
    at_neg(); chk_gnt("t6s1", 1, 0);
    chk("t6s1_rd", bus.mem_read_o, 1);
    push(0, 32'hA00);
    next();
    drv(0, 0, 0, 0, 0, 0);
    at_neg(); chk_gnt("t6e", 0, 0);
    next();

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
